// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO APB master: FSM states and register map.
package gpio_pkg;

    // APB master phases.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    // GPIO register file byte offsets.
    localparam logic [31:0] GpioDirOffset  = 32'h0000_0000;
    localparam logic [31:0] GpioValOffset  = 32'h0000_0004;
    localparam logic [31:0] GpioInvOffset  = 32'h0000_0008;
    localparam logic [31:0] GpioIntEnOffset = 32'h0000_000C;
    localparam logic [31:0] GpioIntTOffset = 32'h0000_0010;

    // Wait-state counter width: must be able to hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches upward from last+1 with wrap-around.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    // First requester after 'last' wins; grant stays zero when nobody requests.
    always_comb begin
        logic [IdxW:0] cand;
        logic          found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(N_REQ)) begin
                cand = cand - (IdxW + 1)'(N_REQ);
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                found                  = 1'b1;
                grant[cand[IdxW-1:0]]  = 1'b1;
                idx                    = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Multi-requester APB master toward the GPIO register file, round-robin arbitrated,
// with an optional wait-state timeout that aborts a stuck transfer.
module gpio_apb_arbiter
    import gpio_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       we_i,
    input  logic [N_REQ-1:0][31:0] addr_i,
    input  logic [N_REQ-1:0][31:0] wdata_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   err_o,
    output logic [31:0]            rdata_o,
    output logic [31:0]            PADDR,
    output logic [31:0]            PWDATA,
    output logic                   PWRITE,
    output logic                   PSEL,
    output logic                   PENABLE,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = cnt_width(TIMEOUT);

    apb_state_e      state_q;
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] win_q;
    logic [CntW-1:0] cnt_q;

    logic [N_REQ-1:0] rr_grant;
    logic [IdxW-1:0]  rr_idx;
    logic             timeout_hit;
    logic [N_REQ-1:0] win_onehot;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req  (req_i),
        .last (last_q),
        .grant(rr_grant),
        .idx  (rr_idx)
    );

    // Grants are only offered while the bus is free.
    assign gnt_o = (state_q == StIdle) ? rr_grant : '0;

    // This ACCESS cycle is the TIMEOUT-th one without PREADY.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

    assign win_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << win_q;

    // Transfer FSM; all APB and completion outputs are registered here.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StIdle;
            last_q  <= IdxW'(N_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            done_o  <= '0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req_i) begin
                        state_q <= StSetup;
                        last_q  <= rr_idx;
                        win_q   <= rr_idx;
                        // PADDR/PWDATA/PWRITE double as the latched request.
                        PADDR   <= addr_i[rr_idx];
                        PWDATA  <= wdata_i[rr_idx];
                        PWRITE  <= we_i[rr_idx];
                        PSEL    <= 1'b1;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    PENABLE <= 1'b1;
                    cnt_q   <= '0;
                end
                StAccess: begin
                    if (PREADY) begin
                        state_q <= StIdle;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        done_o  <= win_onehot;
                        if (!PWRITE) begin
                            rdata_o <= PRDATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (timeout_hit) begin
                            state_q <= StIdle;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            PWRITE  <= 1'b0;
                            done_o  <= win_onehot;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/gpio_apb_arbiter.md
GPIO_APB_ARBITER -- requirements
Module: gpio_apb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2; number of requesters, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 16; maximum ACCESS cycles without PREADY; 0 disables the timeout.
REQ-003 SHALL have port PCLK  in  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port PRESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  in  N_REQ  per-requester transfer request, held until granted.
REQ-006 SHALL have port we_i  in  N_REQ  per-requester direction, 1 = write.
REQ-007 SHALL have port addr_i  in  N_REQ x 32  per-requester byte address.
REQ-008 SHALL have port wdata_i  in  N_REQ x 32  per-requester write data.
REQ-009 SHALL have port gnt_o  out  N_REQ  one-hot, 1-cycle pulse; request accepted, its inputs are sampled.
REQ-010 SHALL have port done_o  out  N_REQ  one-hot, 1-cycle pulse; transfer complete.
REQ-011 SHALL have port err_o  out  1  valid with done_o; 1 = timeout abort.
REQ-012 SHALL have port rdata_o  out  32  read data of the last completion; held until the next completion.
REQ-013 SHALL have ports PADDR out 32, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1, PRDATA in 32, PREADY in 1; APB master toward one slave (gpio register file).

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-015 In IDLE with any req_i set, SHALL combinationally assert gnt_o for the round-robin winner, latch we/addr/wdata, and go to SETUP.
REQ-016 Round-robin SHALL search from (last_q+1) mod N_REQ upward with wrap-around; last_q SHALL update to the winner on each grant.
REQ-017 In SETUP SHALL drive PSEL=1, PENABLE=0 and PADDR/PWRITE/PWDATA from the latched values; next state SHALL be ACCESS unconditionally.
REQ-018 In ACCESS SHALL drive PSEL=1, PENABLE=1 with stable address/data/direction until exit.
REQ-019 In ACCESS with PREADY=1 SHALL go to IDLE; in the next cycle done_o[winner]=1 and err_o=0, and for reads rdata_o=PRDATA as sampled.
REQ-020 A write completion SHALL leave rdata_o unchanged.
REQ-021 Wait-state counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-022 When TIMEOUT!=0 and the counter reaches TIMEOUT, SHALL go to IDLE; in the next cycle done_o[winner]=1, err_o=1, rdata_o=0.
REQ-023 The done_o cycle SHALL coincide with IDLE, so a new grant may occur in the same cycle; minimum 3 cycles per transfer.
REQ-024 Outside SETUP/ACCESS, PSEL and PENABLE SHALL be 0, PWRITE SHALL be 0, and PADDR/PWDATA SHALL hold their last values.
REQ-025 req_i deasserted before grant SHALL be ignored without side effects; req_i changes after grant SHALL not affect the transfer in flight.
REQ-026 gnt_o SHALL only be asserted in IDLE, at most one bit per cycle.

Reset
REQ-027 On PRESET=1 at a clock edge: state=IDLE, last_q=N_REQ-1 (requester 0 wins first), counter=0, PADDR=0, PWDATA=0, PWRITE=0, PSEL=0, PENABLE=0, gnt_o=0, done_o=0, err_o=0, rdata_o=0.
REQ-028 Reset mid-transfer SHALL abort silently: no done_o pulse for the aborted transfer.

Structure
REQ-029 Shared package gpio_pkg SHALL hold the FSM state enum and the GPIO register byte offsets: DIR 0x00, VAL 0x04, INV 0x08, INT_EN 0x0C, INT_T 0x10.
REQ-030 The round-robin picker SHALL be a sub-module rr_arbiter (inputs req, last; outputs one-hot grant and index).

Verification
REQ-031 Write from requester 0 to 0x00, data 0xFF, PREADY tied 1, req at cycle 0 -> gnt_o=01 in cycle 0; PSEL=1 in cycles 1-2; PENABLE=1 in cycle 2; PWRITE=1; done_o=01, err_o=0 in cycle 3.
REQ-032 Read from requester 1 at 0x04, PREADY low for 2 ACCESS cycles, PRDATA=0xA5 -> done_o=10 in cycle 5, rdata_o=0xA5.
REQ-033 Both req_i held high after reset -> grant order 0,1,0,1; one grant every 3 cycles.
REQ-034 PREADY held 0, TIMEOUT=16 -> 16 ACCESS cycles, then PSEL=0, done_o pulse with err_o=1, rdata_o=0.
REQ-035 PRESET pulsed during ACCESS -> next cycle PSEL=PENABLE=0, no done_o; next grant goes to requester 0.
REQ-036 Attached to the GPIO slave: write DIR=0x0F, then VAL=0x05 -> dir_o=0x0F, val_o=0x05; reading 0x00 returns 0x0F.
